// File: rtl/ror_pkg.sv
// Shared constants and a reference rotate-right helper for the rotate arbiter slice.
package ror_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    function automatic logic [DATA_W-1:0] rotr32(input logic [DATA_W-1:0] a,
                                                 input logic [SHAMT_W-1:0] amt);
        return DATA_W'({a, a} >> amt);
    endfunction

endpackage

// File: rtl/ror32_core.sv
// Purely combinational 32-bit rotate-right, built as a 5-stage logarithmic shifter.
module ror32_core
    import ror_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] amt,
    output logic [DATA_W-1:0]  o
);

    logic [DATA_W-1:0] stage [SHAMT_W+1];

    assign stage[0] = a;

    // Stage k rotates by 2**k when amount bit k is set.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage[k+1] = amt[k] ? {stage[k][SH-1:0], stage[k][DATA_W-1:SH]} : stage[k];
    end

    assign o = stage[SHAMT_W];

endmodule

// File: rtl/ror_arbiter.sv
// Round-robin arbiter sharing one rotate-right datapath among N_REQ requesters,
// with a single registered result slot tagged by requester index.
module ror_arbiter
    import ror_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_o,
    output logic [ID_W-1:0]           rsp_id
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // requesters hold valid and data until ready, the result slot holds until rsp_ready.
    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    win_id;
    logic               found;
    logic [N_REQ-1:0]   grant;
    logic               can_accept;
    logic               accept;
    logic [DATA_W-1:0]  sel_a;
    logic [SHAMT_W-1:0] sel_amt;
    logic [DATA_W-1:0]  rot_o;
    logic               unused_b;

    // Scan the doubled request vector above last_id; first hit wins, wrapping naturally.
    always_comb begin
        grant  = '0;
        win_id = '0;
        found  = 1'b0;
        for (int j = 0; j < 2 * N_REQ; j++) begin
            if (!found && (j > int'(last_id)) && req_valid[j % N_REQ]) begin
                found  = 1'b1;
                win_id = ID_W'(j % N_REQ);
            end
        end
        if (found) begin
            grant[win_id] = 1'b1;
        end
    end

    assign can_accept = !rsp_valid || rsp_ready;
    assign req_ready  = rst_n ? (grant & {N_REQ{can_accept}}) : '0;
    assign accept     = |(req_valid & req_ready);

    assign sel_a   = req_a[DATA_W*win_id +: DATA_W];
    assign sel_amt = req_b[DATA_W*win_id +: SHAMT_W];
    assign unused_b = ^req_b;

    ror32_core u_core (
        .a   (sel_a),
        .amt (sel_amt),
        .o   (rot_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_o     <= '0;
            rsp_id    <= '0;
            last_id   <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_o     <= rot_o;
            rsp_id    <= win_id;
            last_id   <= win_id;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ror_arbiter.sv
// Randomized and directed bench for ror_arbiter with a queue-based reference model
// and a decoupled response monitor.
module tb_ror_arbiter;

    localparam int NR = 4;
    localparam int IW = $clog2(NR);
    localparam int W  = IW + 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_a;
    logic [NR*32-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_o;
    logic [IW-1:0]     rsp_id;

    always #5 clk = ~clk;

    ror_arbiter #(.N_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_o     (rsp_o),
        .rsp_id    (rsp_id)
    );

    logic [63:0]  pend [NR][$];
    logic [W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int m_last = NR - 1;
    bit m_rsp_valid = 1'b0;
    bit armed = 1'b0;
    bit just_reset = 1'b0;

    // Bit i of a right-rotate by amt comes from bit (i+amt) mod 32 of the operand.
    function automatic logic [31:0] model_rot(logic [31:0] a, logic [31:0] b);
        int amt;
        logic [31:0] o;
        amt = int'(b % 32);
        for (int i = 0; i < 32; i++) o[i] = a[(i + amt) % 32];
        return o;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NR; k++) begin
            if (pend[(m_last + k) % NR].size() != 0) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_op(int r, logic [31:0] a, logic [31:0] b);
        pend[r].push_back({a, b});
    endtask

    task automatic cycle(bit rstv, bit rdy);
        int w;
        bit can;
        logic [NR-1:0] exp_rr;
        @(negedge clk);
        rst_n = rstv;
        rsp_ready = rdy;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (pend[i].size() != 0);
            if (req_valid[i]) begin
                req_a[32*i +: 32] = pend[i][0][63:32];
                req_b[32*i +: 32] = pend[i][0][31:0];
            end else begin
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
            end
        end
        #1;
        w = pick();
        can = !m_rsp_valid || rdy;
        exp_rr = '0;
        if (rstv && can && w >= 0) exp_rr[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rr));
        if (armed) check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        if (just_reset) begin
            check("reset_rsp_o", 64'(rsp_o), 64'd0);
            check("reset_rsp_id", 64'(rsp_id), 64'd0);
            just_reset = 1'b0;
        end
        #2;
        if (!rstv) begin
            m_rsp_valid = 1'b0;
            m_last = NR - 1;
            exp_q.delete();
            just_reset = 1'b1;
            armed = 1'b1;
        end else if (exp_rr != '0) begin
            exp_q.push_back({IW'(w), model_rot(pend[w][0][63:32], pend[w][0][31:0])});
            void'(pend[w].pop_front());
            m_last = w;
            m_rsp_valid = 1'b1;
        end else if (m_rsp_valid && rdy) begin
            m_rsp_valid = 1'b0;
        end
    endtask

    // Monitor: a held result must equal the oldest expected entry; consumed ones are retired.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (armed && rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got id %0d data %h expected no result", rsp_id, rsp_o);
                end else begin
                    check("rsp_data", 64'({rsp_id, rsp_o}), 64'(exp_q[0]));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        bit busy;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;

        cycle(0, 0);
        cycle(0, 0);
        cycle(1, 1);

        push_op(0, 32'h8000_0001, 32'd1);
        push_op(0, 32'h0000_003F, 32'd6);
        push_op(0, 32'h0000_0001, 32'd31);
        push_op(0, 32'h1234_5678, 32'd0);
        push_op(0, 32'h8000_0001, 32'h21);
        repeat (8) cycle(1, 1);

        for (int b = 0; b < 32; b++) push_op(0, 32'hA5A5_F00F, 32'(b));
        repeat (36) cycle(1, 1);

        cycle(0, 1);
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < NR; r++) push_op(r, $urandom, $urandom);
        repeat (16) cycle(1, 1);

        push_op(3, $urandom, $urandom);
        repeat (3) cycle(1, 1);
        push_op(0, $urandom, $urandom);
        push_op(3, $urandom, $urandom);
        repeat (4) cycle(1, 1);

        push_op(1, $urandom, $urandom);
        push_op(2, $urandom, $urandom);
        repeat (3) cycle(1, 0);
        repeat (4) cycle(1, 1);

        push_op(3, $urandom, $urandom);
        push_op(1, $urandom, $urandom);
        cycle(1, 0);
        cycle(1, 0);
        push_op(0, $urandom, $urandom);
        cycle(0, 0);
        repeat (5) cycle(1, 1);

        repeat (400) begin
            for (int r = 0; r < NR; r++)
                if ($urandom_range(0, 3) == 0) push_op(r, $urandom, $urandom);
            cycle(1, $urandom_range(0, 3) != 0);
        end

        guard = 0;
        busy = 1'b1;
        while (busy && guard < 200) begin
            cycle(1, 1);
            guard++;
            busy = m_rsp_valid;
            for (int r = 0; r < NR; r++) if (pend[r].size() != 0) busy = 1'b1;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", guard);
        end
        cycle(1, 1);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ror_arbiter.md
# ror_arbiter

Round-robin arbiter that shares one 32-bit circular-right-rotate datapath among `N_REQ` independent requesters. Each requester presents an operand and a rotate amount with a valid/ready handshake. The block grants one requester per cycle, rotates its operand and holds the result in a single output register tagged with the requester index. It sits between the execution-lane issue logic and the shared rotate resource, so that rotate hardware is not duplicated per lane.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index; derived, not overridden.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `req_valid`  in  N_REQ  — bit i: requester i presents an operation.
- `req_ready`  out  N_REQ  — bit i: requester i's operation is accepted this cycle.
- `req_a`  in  N_REQ*32  — operand; slice i = `[32*i +: 32]`.
- `req_b`  in  N_REQ*32  — amount word; only bits `[4:0]` of each slice are used.
- `rsp_valid`  out  1  — result register holds a result.
- `rsp_ready`  in  1  — consumer takes the result this cycle.
- `rsp_o`  out  32  — rotated result.
- `rsp_id`  out  ID_W  — index of the requester that produced `rsp_o`.

## Operation
- Rotate function: `amt = b[4:0]`; `o = (a >> amt) | (a << (32-amt))`.
  - Every `amt` 0..31 is valid.
  - `amt = 0` returns `a` unchanged.
  - `b[31:5]` is ignored: `b = 33` behaves as `amt = 1`.
- `can_accept = !rsp_valid || rsp_ready`.
- Grant selection:
  - `grant` is one-hot, combinational from `req_valid` and the priority pointer `last_id`.
  - Search order is `last_id+1, last_id+2, …` modulo `N_REQ`.
  - The first set `req_valid` bit in that order wins.
- `req_ready[i] = grant[i] && can_accept`.
  - At most one bit of `req_ready` is set.
  - `req_ready` is all-zero when no request is valid.
- Accept, when some `req_valid[i] && req_ready[i]`, on that clock edge:
  - `rsp_o <= rotr(a_i, b_i)`;
  - `rsp_id <= i`;
  - `rsp_valid <= 1`;
  - `last_id <= i`.
- Drain, when `rsp_valid && rsp_ready` and no accept: `rsp_valid <= 0`. `rsp_o` and `rsp_id` hold their last values.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and `rsp_valid` stays 1. This gives full throughput of one operation per cycle.
- `last_id` changes only on accept. A stalled or absent request never advances the priority.
- Requester contract:
  - Once `req_valid[i]` is raised, it stays high and `req_a`/`req_b` stay stable until `req_ready[i]`.
  - The arbiter may legally serve another requester first, per round-robin order.
- Starvation bound: a continuously valid requester is accepted within `N_REQ` accepts.
- Reset values: `rsp_valid=0`, `rsp_o=0`, `rsp_id=0`, `last_id=N_REQ-1`. After reset, requester 0 has top priority.
- Reset asserted mid-operation: a pending result is discarded without handshake. `req_ready` is forced to 0 while `rst_n=0`.

## Timing
- Latency: accept at edge k, so `rsp_valid` and the result are visible after edge k and can be consumed at edge k+1.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`.
- `rsp_*` outputs are registered only, with no combinational path from any input.
- Backpressure: while `rsp_valid=1 && rsp_ready=0`:
  - all `req_ready` are 0;
  - `rsp_o` and `rsp_id` are held stable.
- Single-entry buffer: with no consumer, at most one result is ever held.

## Structure
- Shared package `ror_pkg`:
  - `DATA_W=32` and `SHAMT_W=5`;
  - a `rotr32(a, amt)` function for use in RTL and the bench model.
- Sub-module `ror32_core`: a purely combinational rotator (a, amt → o), implemented as a 5-stage log shifter. The arbiter instantiates exactly one.
- The arbiter holds:
  - the round-robin pick logic (a double-width masked priority encode is acceptable);
  - the operand mux;
  - the output register.

## Test plan
- Rotate values, single requester 0, `rsp_ready=1`:
  - `a=0x80000001, b=1` → `0xC0000000`;
  - `a=0x0000003F, b=6` → `0xFC000000`;
  - `a=0x00000001, b=31` → `0x00000002`;
  - `a=0x12345678, b=0` → `0x12345678`;
  - `b=0x21` → same result as `b=1`.
- Exhaustive amount sweep: `a=0xA5A5F00F`, `b` = 0..31 back-to-back → one result per cycle matching `rotr32`, all with `rsp_id=0`.
- Round-robin fairness: all 4 requesters continuously valid from reset, `rsp_ready=1` → `rsp_id` sequence 0,1,2,3,0,1,… with no idle cycles.
- Backpressure: hold `rsp_ready=0` for 3 cycles with requesters 1 and 2 valid.
  - During the stall: `rsp_o`/`rsp_id` stay stable and `req_ready=0`.
  - After release: ids 1 then 2 are delivered, each exactly once.
- Priority hold: only requester 3 valid (accepted), then requesters 0 and 3 both valid → 0 is granted before 3.
- Reset mid-stall: `rst_n=0` for one cycle while `rsp_valid=1`, `rsp_ready=0`.
  - After that edge: `rsp_valid=0`, `rsp_o=0`, `rsp_id=0`.
  - Next grant goes to requester 0.
